// File: rtl/sound_arbiter.sv
// rtl/sound_arbiter.sv - fixed-priority, preemptive arbiter for the single audio playback resource
// Optional build macro SOUND_QUEUE_EN: queue lower-priority requests and replay them after a silent gap.
module sound_arbiter #(
    parameter int CHOMP_TICKS = 1600,
    parameter int POWER_TICKS = 8000,
    parameter int DEATH_TICKS = 12000,
    parameter int INTRO_TICKS = 32000,
    parameter int GAP_TICKS   = 80,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_8khz,
    input  logic [3:0] req,
    input  logic       mute,
    output logic [2:0] sound_type,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

`ifdef SOUND_QUEUE_EN
    localparam logic [3:0] PEND_MASK = 4'hF;
`else
    localparam logic [3:0] PEND_MASK = 4'h0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       id_q, id_d;
    logic             done_q, done_d;
    logic [3:0]       pend_q, pend_d;

    function automatic logic [1:0] top_id(input logic [3:0] v);
        if (v[3]) return 2'd3;
        if (v[2]) return 2'd2;
        if (v[1]) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [CNT_W-1:0] dur(input logic [1:0] id);
        case (id)
            2'd0:    return CNT_W'(CHOMP_TICKS);
            2'd1:    return CNT_W'(POWER_TICKS);
            2'd2:    return CNT_W'(DEATH_TICKS);
            default: return CNT_W'(INTRO_TICKS);
        endcase
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    logic       req_any;
    logic [1:0] req_id;
    logic [3:0] all_v;
    logic [1:0] all_id;
    logic       tick_end;
    logic [3:0] pend_end;

    assign req_any  = |req;
    assign req_id   = top_id(req);
    assign all_v    = req | pend_q;
    assign all_id   = top_id(all_v);
    assign tick_end = tick_8khz && (cnt_q == CNT_W'(1));
    assign pend_end = (pend_q | req) & PEND_MASK;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        done_d  = 1'b0;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = PLAY;
                    id_d    = req_id;
                    cnt_d   = dur(req_id);
                    pend_d  = (pend_q | req) & ~onehot(req_id);
                end
            end
            PLAY: begin
                if (req_any && (req_id > id_q)) begin
                    // Preemption drops the running sound without a done pulse
                    id_d   = req_id;
                    cnt_d  = dur(req_id);
                    pend_d = (pend_q | req) & ~onehot(req_id);
                end else if (tick_end) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    pend_d = pend_end;
                    if (pend_end != 4'h0) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_TICKS);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    pend_d = pend_q | (req & ~onehot(id_q));
                    if (req_any && (req_id == id_q)) begin
                        cnt_d = dur(id_q);
                    end else if (tick_8khz) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (req_any || tick_end) begin
                    state_d = PLAY;
                    id_d    = all_id;
                    cnt_d   = dur(all_id);
                    pend_d  = all_v & ~onehot(all_id);
                end else if (tick_8khz) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = pend_d & PEND_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= 2'd0;
            done_q  <= 1'b0;
            pend_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    // Mute only gates the code seen by the audio block; sequencing is untouched
    assign sound_type = ((state_q == PLAY) && !mute) ? ({1'b0, id_q} + 3'd1) : 3'd0;
    assign busy       = (state_q != IDLE);
    assign active_id  = id_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb/tb_sound_arbiter.sv - vector table, corner sequences and randomized model comparison for sound_arbiter
module tb_sound_arbiter;

`ifdef SOUND_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif
    localparam int GAPT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_8khz = 1'b0;
    logic [3:0] req = 4'h0;
    logic       mute = 1'b0;
    logic [2:0] sound_type;
    logic       busy;
    logic [1:0] active_id;
    logic       done;

    always #5 clk = ~clk;

    sound_arbiter #(
        .CHOMP_TICKS(4), .POWER_TICKS(6), .DEATH_TICKS(8), .INTRO_TICKS(10),
        .GAP_TICKS(GAPT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_8khz(tick_8khz), .req(req), .mute(mute),
        .sound_type(sound_type), .busy(busy), .active_id(active_id), .done(done)
    );

    int checks = 0;
    int failures = 0;
    int ph = 0;

    // Reference model: mode 0 silent/idle, 1 sounding, 2 gap; remaining ticks; pending set
    int       m_mode, m_id, m_rem;
    bit       m_done;
    bit [3:0] m_pend;
    int       dur_t[4] = '{4, 6, 8, 10};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int hi(input bit [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_id = 0; m_rem = 0; m_done = 0; m_pend = 4'h0;
    endtask

    task automatic grant(input int w);
        m_mode = 1; m_id = w; m_rem = dur_t[w]; m_pend[w] = 1'b0;
    endtask

    task automatic add_pend(input bit [3:0] r, input int skip);
        if (QUEUE) for (int i = 0; i < 4; i++) if (r[i] && i != skip) m_pend[i] = 1'b1;
    endtask

    task automatic model_step(input bit [3:0] r, input bit t);
        int w;
        w = hi(r);
        m_done = 0;
        if (m_mode == 0) begin
            if (w >= 0) begin grant(w); add_pend(r, w); end
        end else if (m_mode == 1) begin
            if (w > m_id) begin
                grant(w); add_pend(r, w);
            end else if (t && m_rem == 1) begin
                m_done = 1;
                add_pend(r, -1);
                if (m_pend != 0) begin m_mode = 2; m_rem = GAPT; end
                else begin m_mode = 0; m_rem = 0; end
            end else begin
                add_pend(r, m_id);
                if (w == m_id) m_rem = dur_t[m_id];
                else if (t) m_rem--;
            end
        end else begin
            if (r != 0) begin add_pend(r, -1); grant(hi(m_pend)); end
            else if (t && m_rem == 1) grant(hi(m_pend));
            else if (t) m_rem--;
        end
    endtask

    task automatic cmp_model();
        chk("model sound_type", sound_type, (m_mode == 1 && !mute) ? m_id + 1 : 0);
        chk("model busy", busy, (m_mode != 0) ? 1 : 0);
        chk("model active_id", active_id, m_id);
        chk("model done", done, m_done);
    endtask

    task automatic cycle(input logic [3:0] r, input logic m, input logic t);
        req = r; mute = m; tick_8khz = t;
        model_step(r, t);
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic tcyc(input logic [3:0] r, input logic m);
        cycle(r, m, ph == 4);
        ph = (ph + 1) % 5;
    endtask

    task automatic do_reset();
        req = 4'h0; mute = 1'b0; tick_8khz = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph = 0;
    endtask

    task automatic run_to_done(input int maxc, output int nt, output int nd);
        nt = 0; nd = 0;
        for (int i = 0; i < maxc; i++) begin
            tcyc(4'h0, 1'b0);
            if (tick_8khz) nt++;
            if (done) begin nd++; break; end
        end
    endtask

    typedef struct {
        logic [3:0] r; logic m; logic t;
        logic [2:0] st; logic b; logic [1:0] id; logic d;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int nt, nd, ticks, cur, segt, code, ndone;
        int seg_v[$], seg_n[$], ev[$], en[$];

        tbl[0]  = '{4'b0001, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b1, 3'd1, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 1'b1, 3'd1, 1'b1, 2'd0, 1'b0};
        tbl[3]  = '{4'b0000, 1'b0, 1'b1, 3'd1, 1'b1, 2'd0, 1'b0};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b1};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{4'b1010, 1'b0, 1'b0, 3'd4, 1'b1, 2'd3, 1'b0};
        tbl[8]  = '{4'b0100, 1'b0, 1'b0, 3'd4, 1'b1, 2'd3, 1'b0};
        tbl[9]  = '{4'b1000, 1'b0, 1'b1, 3'd4, 1'b1, 2'd3, 1'b0};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 3'd0, 1'b1, 2'd3, 1'b0};

        do_reset();
        chk("reset sound_type", sound_type, 0);
        chk("reset busy", busy, 0);
        chk("reset active_id", active_id, 0);
        chk("reset done", done, 0);

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].r, tbl[i].m, tbl[i].t);
            chk($sformatf("vec%0d sound_type", i), sound_type, tbl[i].st);
            chk($sformatf("vec%0d busy", i), busy, tbl[i].b);
            chk($sformatf("vec%0d active_id", i), active_id, tbl[i].id);
            chk($sformatf("vec%0d done", i), done, tbl[i].d);
        end

        // Asynchronous reset in the middle of a sound
        do_reset();
        tcyc(4'b0001, 1'b0);
        tcyc(4'b0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset sound_type", sound_type, 0);
        chk("async reset busy", busy, 0);
        chk("async reset done", done, 0);
        chk("async reset active_id", active_id, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        ph = 0;

        // Chomp preempted by death after two ticks
        do_reset();
        tcyc(4'b0001, 1'b0);
        chk("chomp start sound_type", sound_type, 1);
        ticks = 0; ndone = 0;
        for (int i = 0; i < 50 && ticks < 2; i++) begin
            tcyc(4'h0, 1'b0);
            if (tick_8khz) ticks++;
            if (done) ndone++;
        end
        chk("chomp ticks before preempt", ticks, 2);
        tcyc(4'b0100, 1'b0);
        chk("preempt sound_type", sound_type, 3);
        chk("preempt no done", ndone + done, 0);
        run_to_done(300, nt, nd);
        chk("death done seen", nd, 1);
        chk("death ticks after preempt", nt, 8);
        tcyc(4'h0, 1'b0);
        chk("idle after death busy", busy, 0);

        // Death with lower-priority requests arriving behind it
        do_reset();
        tcyc(4'b0100, 1'b0);
        tcyc(4'b0001, 1'b0);
        tcyc(4'b0010, 1'b0);
        seg_v.delete(); seg_n.delete();
        cur = 3; segt = 0; ndone = 0;
        for (int i = 0; i < 600; i++) begin
            tcyc(4'h0, 1'b0);
            if (tick_8khz) segt++;
            if (done) ndone++;
            code = busy ? int'(sound_type) : 7;
            if (code != cur) begin
                seg_v.push_back(cur); seg_n.push_back(segt);
                cur = code; segt = 0;
            end
            if (code == 7) break;
        end
        if (QUEUE) begin ev = '{3, 0, 2, 0, 1}; en = '{8, 2, 6, 2, 4}; end
        else       begin ev = '{3}; en = '{8}; end
        chk("queue segment count", seg_v.size(), ev.size());
        chk("queue done count", ndone, QUEUE ? 3 : 1);
        chk("queue ends idle", busy, 0);
        for (int i = 0; i < ev.size() && i < seg_v.size(); i++) begin
            chk($sformatf("queue seg%0d sound", i), seg_v[i], ev[i]);
            chk($sformatf("queue seg%0d ticks", i), seg_n[i], en[i]);
        end

        // Same-id retrigger on the fifth of six ticks, with a mute window
        do_reset();
        tcyc(4'b0010, 1'b0);
        ticks = 0;
        for (int i = 0; i < 50 && ticks < 4; i++) begin
            tcyc(4'h0, 1'b0);
            if (tick_8khz) ticks++;
        end
        for (int i = 0; i < 6 && ph != 4; i++) tcyc(4'h0, 1'b0);
        tcyc(4'b0010, 1'b0);
        chk("retrigger on tick", tick_8khz, 1);
        chk("retrigger sound_type", sound_type, 2);
        chk("retrigger no done", done, 0);
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            tcyc(4'h0, 1'b1);
            if (tick_8khz) ticks++;
            chk("mute sound_type", sound_type, 0);
            chk("mute active_id", active_id, 1);
            chk("mute busy", busy, 1);
        end
        tcyc(4'h0, 1'b0);
        if (tick_8khz) ticks++;
        chk("unmute sound_type", sound_type, 2);
        run_to_done(300, nt, nd);
        chk("retrigger done seen", nd, 1);
        chk("retrigger ticks to done", ticks + nt, 6);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cycle(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
